// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register: decodes the ID instruction into ALU operands, op select and MEM/WB controls.
// Optional build macro ALU_SHIFT_EXT_EN adds sll decode (aluctrl 3); without it sll is illegal.
module id_ex_alu_issue #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] id_instr,
   input  logic [DATA_W-1:0] id_rs_val,
   input  logic [DATA_W-1:0] id_rt_val,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [3:0]        ex_aluctrl,
   output logic [DATA_W-1:0] ex_rt_val,
   output logic [REG_AW-1:0] ex_wreg,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              ex_illegal
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_OR   = 4'd2;
   localparam logic [3:0] ALU_SLL  = 4'd3;

   logic [5:0]        op_s;
   logic [5:0]        funct_s;
   logic [15:0]       imm_s;
   logic [REG_AW-1:0] rt_idx_s;
   logic [REG_AW-1:0] rd_idx_s;
   logic [4:0]        shamt_s;
   logic [DATA_W-1:0] imm_sext_s;
   logic [DATA_W-1:0] imm_zext_s;
   logic [DATA_W-1:0] imm_lui_s;
   logic              unused_s;

   assign op_s       = id_instr[31:26];
   assign funct_s    = id_instr[5:0];
   assign imm_s      = id_instr[15:0];
   assign rt_idx_s   = id_instr[16 +: REG_AW];
   assign rd_idx_s   = id_instr[11 +: REG_AW];
   assign shamt_s    = id_instr[10:6];
   assign imm_sext_s = {{(DATA_W-16){imm_s[15]}}, imm_s};
   assign imm_zext_s = {{(DATA_W-16){1'b0}}, imm_s};
   assign imm_lui_s  = {imm_s, {(DATA_W-16){1'b0}}};
   // rs index is resolved upstream; only its forwarded value arrives here
   assign unused_s   = ^{id_instr[25:21], shamt_s};

   logic [DATA_W-1:0] a_s;
   logic [DATA_W-1:0] b_s;
   logic [3:0]        aluctrl_s;
   logic [DATA_W-1:0] rt_val_s;
   logic [REG_AW-1:0] wreg_s;
   logic              regwrite_s;
   logic              memread_s;
   logic              memwrite_s;
   logic              live_s;
   logic              illegal_s;

   // Instruction decode into next EX-stage contents
   always_comb begin
      a_s        = '0;
      b_s        = '0;
      aluctrl_s  = ALU_ADD;
      wreg_s     = '0;
      regwrite_s = 1'b0;
      memread_s  = 1'b0;
      memwrite_s = 1'b0;
      live_s     = 1'b0;
      illegal_s  = 1'b0;
      case (op_s)
         OP_RTYPE: begin
            case (funct_s)
               FN_ADDU: begin
                  live_s     = 1'b1;
                  a_s        = id_rs_val;
                  b_s        = id_rt_val;
                  aluctrl_s  = ALU_ADD;
                  wreg_s     = rd_idx_s;
                  regwrite_s = 1'b1;
               end
               FN_SUBU: begin
                  live_s     = 1'b1;
                  a_s        = id_rs_val;
                  b_s        = id_rt_val;
                  aluctrl_s  = ALU_SUB;
                  wreg_s     = rd_idx_s;
                  regwrite_s = 1'b1;
               end
               FN_SLL: begin
                  // the all-zero word is the canonical nop, never an sll
                  if (id_instr == '0) begin
                     illegal_s = 1'b0;
                  end else begin
`ifdef ALU_SHIFT_EXT_EN
                     live_s     = 1'b1;
                     a_s        = id_rt_val;
                     b_s        = {{(DATA_W-5){1'b0}}, shamt_s};
                     aluctrl_s  = ALU_SLL;
                     wreg_s     = rd_idx_s;
                     regwrite_s = 1'b1;
`else
                     illegal_s  = 1'b1;
`endif
                  end
               end
               default: illegal_s = 1'b1;
            endcase
         end
         OP_ORI: begin
            live_s     = 1'b1;
            a_s        = id_rs_val;
            b_s        = imm_zext_s;
            aluctrl_s  = ALU_OR;
            wreg_s     = rt_idx_s;
            regwrite_s = 1'b1;
         end
         OP_LUI: begin
            live_s     = 1'b1;
            a_s        = '0;
            b_s        = imm_lui_s;
            aluctrl_s  = ALU_OR;
            wreg_s     = rt_idx_s;
            regwrite_s = 1'b1;
         end
         OP_LW: begin
            live_s     = 1'b1;
            a_s        = id_rs_val;
            b_s        = imm_sext_s;
            aluctrl_s  = ALU_ADD;
            wreg_s     = rt_idx_s;
            regwrite_s = 1'b1;
            memread_s  = 1'b1;
         end
         OP_SW: begin
            live_s     = 1'b1;
            a_s        = id_rs_val;
            b_s        = imm_sext_s;
            aluctrl_s  = ALU_ADD;
            memwrite_s = 1'b1;
         end
         OP_BEQ, OP_J, OP_JAL: illegal_s = 1'b0;
         default: illegal_s = 1'b1;
      endcase

      if (live_s) begin
         rt_val_s = id_rt_val;
      end else begin
         rt_val_s = '0;
      end

      // $0 is hardwired, so a write to it is dropped here
      if (wreg_s == '0) begin
         regwrite_s = 1'b0;
      end else begin
         regwrite_s = regwrite_s;
      end
   end

   // Pipeline register: reset > flush > stall > load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_a        <= '0;
         ex_b        <= '0;
         ex_aluctrl  <= 4'd0;
         ex_rt_val   <= '0;
         ex_wreg     <= '0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_illegal  <= 1'b0;
      end else if (flush) begin
         ex_a        <= '0;
         ex_b        <= '0;
         ex_aluctrl  <= 4'd0;
         ex_rt_val   <= '0;
         ex_wreg     <= '0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_illegal  <= 1'b0;
      end else if (stall) begin
         ex_a        <= ex_a;
         ex_b        <= ex_b;
         ex_aluctrl  <= ex_aluctrl;
         ex_rt_val   <= ex_rt_val;
         ex_wreg     <= ex_wreg;
         ex_regwrite <= ex_regwrite;
         ex_memread  <= ex_memread;
         ex_memwrite <= ex_memwrite;
         ex_illegal  <= ex_illegal;
      end else begin
         ex_a        <= a_s;
         ex_b        <= b_s;
         ex_aluctrl  <= aluctrl_s;
         ex_rt_val   <= rt_val_s;
         ex_wreg     <= wreg_s;
         ex_regwrite <= regwrite_s;
         ex_memread  <= memread_s;
         ex_memwrite <= memwrite_s;
         ex_illegal  <= illegal_s;
      end
   end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Self-checking bench for id_ex_alu_issue: directed cases plus randomized traffic against a reference model.
module tb_id_ex_alu_issue;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic [31:0] id_instr;
   logic [31:0] id_rs_val;
   logic [31:0] id_rt_val;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic [3:0]  ex_aluctrl;
   logic [31:0] ex_rt_val;
   logic [4:0]  ex_wreg;
   logic        ex_regwrite;
   logic        ex_memread;
   logic        ex_memwrite;
   logic        ex_illegal;

   int total;
   int bad;

`ifdef ALU_SHIFT_EXT_EN
   localparam bit SHIFT_EN = 1'b1;
`else
   localparam bit SHIFT_EN = 1'b0;
`endif

   // {a, b, aluctrl, rt_val, wreg, regwrite, memread, memwrite, illegal}
   logic [108:0] obs;
   assign obs = {ex_a, ex_b, ex_aluctrl, ex_rt_val, ex_wreg,
                 ex_regwrite, ex_memread, ex_memwrite, ex_illegal};

   id_ex_alu_issue #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_instr(id_instr), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
      .ex_a(ex_a), .ex_b(ex_b), .ex_aluctrl(ex_aluctrl), .ex_rt_val(ex_rt_val),
      .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_memwrite(ex_memwrite), .ex_illegal(ex_illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction semantics straight from the ISA table, returned as the packed output vector
   function automatic logic [108:0] model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] rtv;
      logic [3:0]  ctl;
      logic [4:0]  dst;
      bit          rw;
      bit          mr;
      bit          mw;
      bit          ill;
      bit          live;
      op = ins[31:26]; fn = ins[5:0];
      a = 32'd0; b = 32'd0; rtv = 32'd0; ctl = 4'd0; dst = 5'd0;
      rw = 1'b0; mr = 1'b0; mw = 1'b0; ill = 1'b0; live = 1'b0;
      if (ins == 32'd0) begin
         live = 1'b0;
      end else if (op == 6'h00 && fn == 6'h21) begin
         live = 1'b1; a = rs; b = rt; ctl = 4'd0; dst = ins[15:11]; rw = 1'b1;
      end else if (op == 6'h00 && fn == 6'h23) begin
         live = 1'b1; a = rs; b = rt; ctl = 4'd1; dst = ins[15:11]; rw = 1'b1;
      end else if (op == 6'h00 && fn == 6'h00 && SHIFT_EN) begin
         live = 1'b1; a = rt; b = 32'(ins[10:6]); ctl = 4'd3; dst = ins[15:11]; rw = 1'b1;
      end else if (op == 6'h0D) begin
         live = 1'b1; a = rs; b = 32'(ins[15:0]); ctl = 4'd2; dst = ins[20:16]; rw = 1'b1;
      end else if (op == 6'h0F) begin
         live = 1'b1; a = 32'd0; b = 32'(ins[15:0]) * 32'd65536; ctl = 4'd2; dst = ins[20:16]; rw = 1'b1;
      end else if (op == 6'h23) begin
         live = 1'b1; a = rs; b = 32'($signed(ins[15:0])); dst = ins[20:16]; rw = 1'b1; mr = 1'b1;
      end else if (op == 6'h2B) begin
         live = 1'b1; a = rs; b = 32'($signed(ins[15:0])); mw = 1'b1;
      end else if (op == 6'h04 || op == 6'h02 || op == 6'h03) begin
         live = 1'b0;
      end else begin
         ill = 1'b1;
      end
      if (live) rtv = rt;
      if (dst == 5'd0) rw = 1'b0;
      return {a, b, ctl, rtv, dst, rw, mr, mw, ill};
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                        input logic st, input logic fl);
      id_instr = ins; id_rs_val = rs; id_rt_val = rt; stall = st; flush = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [108:0] exp_v;
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      id_instr = 32'h00221821; id_rs_val = 32'd5; id_rt_val = 32'd7;
      repeat (2) @(posedge clk);
      #1;
      exp_v = '0;
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset_init got=%h exp=%h", obs, exp_v); end
      reset = 1'b0;
      drive(32'h00221821, 32'd5, 32'd7, 1'b0, 1'b0);
      exp_v = {32'd5, 32'd7, 4'd0, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset_preload got=%h exp=%h", obs, exp_v); end
      #1 reset = 1'b1;
      #1;
      exp_v = '0;
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset_async got=%h exp=%h", obs, exp_v); end
      #1 reset = 1'b0;
   endtask

   task automatic test_arith();
      logic [108:0] exp_v;
      drive(32'h00221821, 32'd5, 32'd7, 1'b0, 1'b0);
      exp_v = {32'd5, 32'd7, 4'd0, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL addu got=%h exp=%h", obs, exp_v); end
      drive(32'h00221823, 32'd5, 32'd7, 1'b0, 1'b0);
      exp_v = {32'd5, 32'd7, 4'd1, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL subu got=%h exp=%h", obs, exp_v); end
      drive(32'h00220021, 32'd5, 32'd7, 1'b0, 1'b0);
      exp_v = {32'd5, 32'd7, 4'd0, 32'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL addu_r0 got=%h exp=%h", obs, exp_v); end
   endtask

   task automatic test_imm();
      logic [108:0] exp_v;
      drive(32'h34858000, 32'h1, 32'h22, 1'b0, 1'b0);
      exp_v = {32'h1, 32'h00008000, 4'd2, 32'h22, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL ori got=%h exp=%h", obs, exp_v); end
      drive(32'h3C081234, 32'hFFFFFFFF, 32'h33, 1'b0, 1'b0);
      exp_v = {32'h0, 32'h12340000, 4'd2, 32'h33, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL lui got=%h exp=%h", obs, exp_v); end
   endtask

   task automatic test_mem();
      logic [108:0] exp_v;
      drive(32'h8CE6FFFC, 32'h100, 32'h44, 1'b0, 1'b0);
      exp_v = {32'h100, 32'hFFFFFFFC, 4'd0, 32'h44, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL lw got=%h exp=%h", obs, exp_v); end
      drive(32'hACE6FFFC, 32'h200, 32'hDEAD, 1'b0, 1'b0);
      exp_v = {32'h200, 32'hFFFFFFFC, 4'd0, 32'hDEAD, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL sw got=%h exp=%h", obs, exp_v); end
   endtask

   task automatic test_bubbles();
      logic [108:0] exp_v;
      drive(32'h10220003, 32'h5, 32'h7, 1'b0, 1'b0);
      exp_v = '0;
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL beq_bubble got=%h exp=%h", obs, exp_v); end
      drive(32'hFC000000, 32'h5, 32'h7, 1'b0, 1'b0);
      exp_v = {108'd0, 1'b1};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL illegal_pulse got=%h exp=%h", obs, exp_v); end
      drive(32'h00000000, 32'h5, 32'h7, 1'b0, 1'b0);
      exp_v = '0;
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL illegal_clear got=%h exp=%h", obs, exp_v); end
      drive(32'h00021080, 32'h5, 32'h7, 1'b0, 1'b0);
      if (SHIFT_EN) exp_v = {32'h7, 32'd2, 4'd3, 32'h7, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0};
      else          exp_v = {108'd0, 1'b1};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL sll got=%h exp=%h", obs, exp_v); end
   endtask

   task automatic test_stall_flush();
      logic [108:0] exp_v;
      drive(32'h00221821, 32'd5, 32'd7, 1'b0, 1'b0);
      exp_v = {32'd5, 32'd7, 4'd0, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
         drive(32'h34858000, 32'h99, 32'h88, 1'b1, 1'b0);
         total++;
         if (obs !== exp_v) begin bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs, exp_v); end
      end
      drive(32'h34858000, 32'h99, 32'h88, 1'b1, 1'b1);
      exp_v = '0;
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL stall_flush got=%h exp=%h", obs, exp_v); end
      drive(32'hFC000000, 32'h1, 32'h2, 1'b0, 1'b0);
      drive(32'h00221821, 32'h1, 32'h2, 1'b1, 1'b0);
      exp_v = {108'd0, 1'b1};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL stall_illegal_hold got=%h exp=%h", obs, exp_v); end
      drive(32'h00221821, 32'h1, 32'h2, 1'b0, 1'b1);
      exp_v = '0;
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL flush got=%h exp=%h", obs, exp_v); end
   endtask

   task automatic test_random();
      logic [108:0] exp_v;
      logic [31:0]  ins;
      logic [31:0]  rs;
      logic [31:0]  rt;
      logic [14:0]  fld;
      logic         st;
      logic         fl;
      exp_v = obs;
      // seed the expected state from a known load rather than the DUT
      drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      exp_v = '0;
      for (int n = 0; n < 400; n++) begin
         fld = 15'($urandom);
         case ($urandom_range(0, 11))
            0:  ins = {6'h00, fld, 5'd0, 6'h21};
            1:  ins = {6'h00, fld, 5'd0, 6'h23};
            2:  ins = {6'h0D, 10'($urandom), 16'($urandom)};
            3:  ins = {6'h0F, 10'($urandom), 16'($urandom)};
            4:  ins = {6'h23, 10'($urandom), 16'($urandom)};
            5:  ins = {6'h2B, 10'($urandom), 16'($urandom)};
            6:  ins = {6'h04, 26'($urandom)};
            7:  ins = 32'h0;
            8:  ins = {6'h00, fld, 5'($urandom), 6'h00};
            9:  ins = {6'h00, 20'($urandom), 6'($urandom)};
            10: ins = {6'h03, 26'($urandom)};
            default: ins = $urandom;
         endcase
         rs = $urandom; rt = $urandom;
         st = ($urandom_range(0, 4) == 0);
         fl = ($urandom_range(0, 9) == 0);
         if (fl)       exp_v = '0;
         else if (!st) exp_v = model(ins, rs, rt);
         drive(ins, rs, rt, st, fl);
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL rand%0d ins=%h st=%0b fl=%0b got=%h exp=%h", n, ins, st, fl, obs, exp_v);
         end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      test_reset();
      test_arith();
      test_imm();
      test_mem();
      test_bubbles();
      test_stall_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ex_alu_issue.md
Name: id_ex_alu_issue

Overview:
ID/EX pipeline stage of the five-stage MIPS core and the producer side of the EX-stage ALU interface.
- Decodes the ID-stage instruction into the ALU's 4-bit operation select (0 add, 1 sub, 2 or).
- Selects and extends ALU operands: register value, sign-extended immediate, zero-extended immediate, or lui-shifted immediate.
- Registers operands and operation with the write-back and memory controls.
- Honours stall and flush from the hazard unit. EX-stage outputs feed the ALU operand and control inputs directly.

Parameters:
DATA_W, 32, datapath width for operands and instruction
REG_AW, 5, register-file address width

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high; clears the stage to a bubble
stall  input  1  hazard unit: hold current EX contents
flush  input  1  hazard unit: load a bubble next edge
id_instr  input  32  instruction in ID
id_rs_val  input  32  forwarded rs value
id_rt_val  input  32  forwarded rt value
ex_a  output  32  ALU operand a
ex_b  output  32  ALU operand b
ex_aluctrl  output  4  ALU operation select
ex_rt_val  output  32  store data for the MEM stage
ex_wreg  output  5  destination register
ex_regwrite  output  1  write-back enable
ex_memread  output  1  load in flight
ex_memwrite  output  1  store in flight
ex_illegal  output  1  one-cycle flag: undecodable instruction was issued as a bubble

Behaviour:
- Reset (async): all outputs 0, which is the bubble state. Bubble state: aluctrl 0, a/b 0, wreg 0, all enables 0.
- Latency: 1 clock. Outputs reflect id_* sampled at the previous rising edge.
- Priority per edge: reset > flush > stall > load.
- flush and stall asserted together: flush wins and the stage loads a bubble.
- Stall: every output register holds, including ex_illegal (it is not re-pulsed).
- Decode (op = instr[31:26], funct = instr[5:0]):
  - R-type, funct 0x21 (addu): a=rs, b=rt, aluctrl 0, wreg=rd, regwrite 1.
  - R-type, funct 0x23 (subu): a=rs, b=rt, aluctrl 1, wreg=rd, regwrite 1.
  - 0x0D (ori): a=rs, b=zero-extended imm, aluctrl 2, wreg=rt, regwrite 1.
  - 0x0F (lui): a=0 (rs value ignored), b={imm,16'h0}, aluctrl 2, wreg=rt, regwrite 1.
  - 0x23 (lw): a=rs, b=sign-extended imm, aluctrl 0, wreg=rt, regwrite 1, memread 1.
  - 0x2B (sw): a=rs, b=sign-extended imm, aluctrl 0, memwrite 1, regwrite 0, ex_rt_val=rt.
  - 0x04 (beq), 0x02 (j), 0x03 (jal): resolved in ID, so they load a legal bubble with ex_illegal 0.
  - instr==0 (nop): bubble, ex_illegal 0.
  - Any other encoding: bubble, and ex_illegal=1 for exactly that load cycle.
- Writes to $0: if the computed wreg==0, regwrite is forced to 0 and wreg stays 0.
- ex_rt_val is always registered from id_rt_val on a load, and is 0 in a bubble.
- Arithmetic: all extension is done in this block. The ALU receives full 32-bit operands and overflow is ignored.

Optional Feature:
Macro: ALU_SHIFT_EXT_EN.
- Defined: R-type funct 0x00 with instr != 0 (sll) decodes to a=rt, b={27'b0, shamt}, aluctrl 3, wreg=rd, regwrite 1. This requires the ALU to implement a << b[4:0] at select 3.
- Undefined: that encoding is illegal, giving a bubble and an ex_illegal pulse. aluctrl values above 2 are never produced.

Test Plan:
- Reset mid-operation: assert reset asynchronously after loading 0x00221821 -> all outputs 0 immediately, before the next clk edge.
- addu $3,$1,$2: id_instr 0x00221821, rs_val 5, rt_val 7 -> next cycle a=5, b=7, aluctrl 0, wreg 3, regwrite 1. Same fields with 0x00221823 (subu) -> aluctrl 1.
- ori $5,$4,0x8000: instr 0x34858000, rs_val 0x1 -> b=0x00008000, aluctrl 2, wreg 5. lui $8,0x1234: instr 0x3C081234 with rs_val 0xFFFFFFFF -> a=0, b=0x12340000, aluctrl 2.
- lw $6,-4($7): instr 0x8CE6FFFC, rs_val 0x100 -> a=0x100, b=0xFFFFFFFC, aluctrl 0, memread 1, wreg 6.
- Stall/flush: load addu, then stall 2 cycles with id_instr changed -> outputs unchanged. Then stall and flush together -> bubble (all 0).
- Illegal opcode 0xFC000000 -> bubble with ex_illegal=1 for one cycle. Addu to $0 (0x00220021) -> regwrite 0, wreg 0.
